bist_tpg: RTL

Test pattern generator and sequencing front end for the AES built-in self-test path. It produces pseudo-random 128-bit plaintext/key pairs from two LFSRs and hands each pair to the AES core with a valid/ready handshake. It waits for the core's completion and then strobes `ora_enable` for one cycle, so the output response analyzer compresses exactly one ciphertext per pattern. It stops after a fixed pattern count and raises `done`, or raises `error` if the core stalls.

---
 rtl/bist_pkg.sv | 36 +++
 rtl/bist_tpg_if.sv | 32 +++
 rtl/lfsr128.sv | 42 ++++
 rtl/bist_tpg.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the AES BIST pattern generator.
//   - state_e          : sequencing FSM states
//   - LFSR_W, TAP_*    : LFSR width and feedback taps (x^128 + x^7 + x^2 + x + 1)
//   - DEFAULT_SEED_*   : default plaintext/key seeds
//   - lfsr_next()      : one Fibonacci shift-left step
//   - seed_fix()       : replaces an all-zero seed, which would lock up the LFSR
package bist_pkg;

  localparam int LFSR_W = 128;

  localparam int TAP_A = 127;
  localparam int TAP_B = 6;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED_PT  = 128'h1;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED_KEY = 128'h0123456789ABCDEF0FEDCBA987654321;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STROBE,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/bist_tpg_if.sv
// bist_tpg_if: pattern handshake between the BIST pattern generator and the AES core.
//   pattern_valid : generator -> core, plaintext/key are valid
//   plaintext     : generator -> core, 128-bit plaintext
//   key           : generator -> core, 128-bit key
//   aes_ready     : core -> generator, core accepts the pattern this cycle
//   aes_done      : core -> generator, one-cycle pulse, ciphertext valid
interface bist_tpg_if;
  import bist_pkg::*;

  logic              pattern_valid;
  logic [LFSR_W-1:0] plaintext;
  logic [LFSR_W-1:0] key;
  logic              aes_ready;
  logic              aes_done;

  modport master (
    output pattern_valid,
    output plaintext,
    output key,
    input  aes_ready,
    input  aes_done
  );

  modport slave (
    input  pattern_valid,
    input  plaintext,
    input  key,
    output aes_ready,
    output aes_done
  );

endinterface

// File: rtl/lfsr128.sv
// lfsr128: 128-bit Fibonacci LFSR with synchronous seed load.
//   clk, rst  : clock, asynchronous active-low reset (state <- RESET_SEED)
//   load      : load seed (zero seed replaced by 1); wins over advance
//   seed      : value to load
//   advance   : take one LFSR step
//   state     : current register contents
module lfsr128
  import bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED_PT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed_fix(seed);
    end else if (advance) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= seed_fix(RESET_SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bist_tpg.sv
// bist_tpg: AES BIST test pattern generator and sequencer.
// Issues NUM_PATTERNS plaintext/key pairs, one ORA strobe per completed
// encryption, then raises done; raises error if the core does not finish
// within TIMEOUT+1 cycles of accepting a pattern.
//   clk, rst      : clock, asynchronous active-low reset
//   bist_start    : level, starts a run from IDLE/DONE/ERROR
//   aes           : pattern handshake to the AES core (master side)
//   ora_enable    : one-cycle strobe per completed pattern
//   pattern_count : patterns completed in this run
//   busy          : run in progress
//   done, error   : run outcome, held until the next start
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | after reset, waiting for bist_start
// ST_ISSUE  | pattern_valid high, waiting for aes_ready
// ST_WAIT   | pattern accepted, waiting for aes_done or timeout
// ST_STROBE | ora_enable high, LFSRs step, count increments
// ST_DONE   | all patterns completed, waiting for bist_start
// ST_ERROR  | core timed out, waiting for bist_start
module bist_tpg
  import bist_pkg::*;
#(
  parameter int unsigned       NUM_PATTERNS = 62,
  parameter logic [LFSR_W-1:0] SEED_PT      = DEFAULT_SEED_PT,
  parameter logic [LFSR_W-1:0] SEED_KEY     = DEFAULT_SEED_KEY,
  parameter int unsigned       TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bist_start,
  bist_tpg_if.master  aes,
  output logic        ora_enable,
  output logic [7:0]  pattern_count,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0]  NUM_PAT_C = 8'(NUM_PATTERNS);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pv_q, pv_d;
  logic        ora_q, ora_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        lfsr_load;
  logic        lfsr_adv;

  logic [LFSR_W-1:0] pt_state;
  logic [LFSR_W-1:0] key_state;

  lfsr128 #(.RESET_SEED(SEED_PT)) u_lfsr_pt (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (SEED_PT),
    .advance (lfsr_adv),
    .state   (pt_state)
  );

  lfsr128 #(.RESET_SEED(SEED_KEY)) u_lfsr_key (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (SEED_KEY),
    .advance (lfsr_adv),
    .state   (key_state)
  );

  // Timeout is a down-counter loaded at accept; reaching zero without
  // aes_done means TIMEOUT+1 WAIT cycles have elapsed.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bist_start) begin
          lfsr_load = 1'b1;
          cnt_d     = '0;
          tmr_d     = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (aes.aes_ready) begin
          tmr_d   = TIMEOUT_C;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (aes.aes_done) begin
          state_d = ST_STROBE;
        end else if (tmr_q == '0) begin
          state_d = ST_ERROR;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      ST_STROBE: begin
        lfsr_adv = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        state_d  = (cnt_d == NUM_PAT_C) ? ST_DONE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    pv_d   = (state_d == ST_ISSUE);
    ora_d  = (state_d == ST_STROBE);
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_STROBE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      ora_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      ora_q   <= ora_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign aes.pattern_valid = pv_q;
  assign aes.plaintext     = pt_state;
  assign aes.key           = key_state;
  assign ora_enable        = ora_q;
  assign pattern_count     = cnt_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = err_q;

endmodule
